sqrt_sched: RTL and testbench

SQRT_SCHED -- requirements
Module: sqrt_sched

---
 rtl/sqrt_sched.sv | 135 +++++++++++++
 tb/tb_sqrt_sched.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_sched.sv
// sqrt_sched: two-requester integer square-root unit.
// One shared iterative engine finds floor(sqrt(radicand)) by stepping a
// candidate upward from 0 until the next square would exceed the radicand.
// Requesters are arbitrated round-robin by default. Defining
// SQRT_SCHED_FIXED_PRIO_EN switches to fixed priority (port 0 always wins)
// and removes the priority pointer; ports and timing are unchanged.
module sqrt_sched #(
  parameter int RAD_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0,
  input  logic               req1,
  input  logic [RAD_W-1:0]   rad0,
  input  logic [RAD_W-1:0]   rad1,
  output logic               gnt0,
  output logic               gnt1,
  output logic               done0,
  output logic               done1,
  output logic [RAD_W/2-1:0] root,
  output logic               exact,
  output logic               busy
);

  localparam int RW = RAD_W / 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [RW-1:0]      r_cand;
  logic [RAD_W-1:0]   r_rad;
  logic               r_sel;
  logic               w_accept;
  logic               w_pick;
  logic               w_calc_end;
  logic [RW:0]        w_cand_inc;
  logic [RAD_W+1:0]   w_next_sq;
  logic               w_exact;

  // Square of a (RW+1)-bit value, evaluated two bits wider than the radicand
  // so that (2^RW)^2 cannot wrap when the candidate sits at its maximum.
  function automatic logic [RAD_W+1:0] f_square(input logic [RW:0] v);
    logic [RAD_W+1:0] ext;
    ext = {{(RAD_W+1-RW){1'b0}}, v};
    return ext * ext;
  endfunction

  assign w_accept   = (r_state == S_IDLE) && (req0 || req1);
  assign w_cand_inc = {1'b0, r_cand} + (RW+1)'(1);
  assign w_next_sq  = f_square(w_cand_inc);
  // Stop when the candidate is saturated or the next square overshoots.
  assign w_calc_end = (&r_cand) || (w_next_sq > {2'b00, r_rad});
  assign w_exact    = (f_square({1'b0, r_cand}) == {2'b00, r_rad});

`ifdef SQRT_SCHED_FIXED_PRIO_EN
  // Port 0 wins whenever it is requesting.
  assign w_pick = ~req0;
`else
  logic r_ptr;

  // Contention goes to the pointer's port; otherwise the lone requester wins.
  assign w_pick = (req0 && req1) ? r_ptr : req1;

  // Pointer hands preference to the port not just served as the unit frees up.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ptr <= 1'b0;
    end else if (r_state == S_DONE) begin
      r_ptr <= ~r_sel;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; DONE always returns to IDLE so accepts never chain.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = S_CALC;
      S_CALC:  if (w_calc_end) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Operand capture on accept and candidate stepping during CALC.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cand <= '0;
      r_rad  <= '0;
      r_sel  <= 1'b0;
    end else if (w_accept) begin
      r_cand <= '0;
      r_rad  <= w_pick ? rad1 : rad0;
      r_sel  <= w_pick;
    end else if ((r_state == S_CALC) && !w_calc_end) begin
      r_cand <= r_cand + RW'(1);
    end
  end

  // Outputs decoded from state; result lines stay at 0 outside DONE.
  always_comb begin
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    done0 = 1'b0;
    done1 = 1'b0;
    root  = '0;
    exact = 1'b0;
    busy  = (r_state != S_IDLE);
    if (r_state != S_IDLE) begin
      gnt0 = ~r_sel;
      gnt1 = r_sel;
    end
    if (r_state == S_DONE) begin
      done0 = ~r_sel;
      done1 = r_sel;
      root  = r_cand;
      exact = w_exact;
    end
  end

endmodule

// File: tb/tb_sqrt_sched.sv
// tb_sqrt_sched: directed and randomized checks of sqrt_sched (RAD_W = 8).
// Expected results come from an arithmetic floor-sqrt, a latency rule of
// floor(sqrt(x))+2 cycles, and a simple arbitration model.
module tb_sqrt_sched;

  localparam int RAD_W = 8;
  localparam int RW    = RAD_W / 2;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic          req0  = 1'b0;
  logic          req1  = 1'b0;
  logic [RAD_W-1:0] rad0 = '0;
  logic [RAD_W-1:0] rad1 = '0;
  logic          gnt0, gnt1, done0, done1, exact, busy;
  logic [RW-1:0] root;

  int n_checks = 0;
  int n_fail   = 0;
  int ptr_m    = 0;

  sqrt_sched #(.RAD_W(RAD_W)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .rad0(rad0), .rad1(rad1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .root(root), .exact(exact), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int isqrt(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  function automatic int pick(input logic r0, input logic r1);
`ifdef SQRT_SCHED_FIXED_PRIO_EN
    return r0 ? 0 : 1;
`else
    if (r0 && r1) return ptr_m;
    return r1 ? 1 : 0;
`endif
  endfunction

  // Advance one clock; observe 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    chk("gnt_exclusive", {31'd0, gnt0 & gnt1}, 0);
    chk("done_exclusive", {31'd0, done0 & done1}, 0);
    if (!(done0 || done1)) begin
      chk("root_idle_zero", {28'd0, root}, 0);
      chk("exact_idle_zero", {31'd0, exact}, 0);
    end
  endtask

  // Serve one operation from IDLE. Latency is counted as the edge that ends
  // the done cycle, relative to the accept edge.
  // release_mode: 0 keep requests, 1 drop served port, 2 drop both.
  task automatic serve(input int exp_port, input int drop_mid, input int new_rad,
                       input int release_mode, output int lat, output int got_root,
                       output int got_exact, output int waited);
    int rad_val;
    int r;
    int steps;
    lat = 0; got_root = -1; got_exact = -1; waited = 0;
    rad_val = (exp_port == 1) ? int'(rad1) : int'(rad0);
    do begin
      step();
      waited++;
    end while (!(gnt0 || gnt1) && waited < 20);
    chk("accept_seen", {31'd0, gnt0 | gnt1}, 1);
    if (!(gnt0 || gnt1)) return;
    chk("gnt_port", {31'd0, gnt1}, exp_port);
    chk("busy_active", {31'd0, busy}, 1);
    if (drop_mid != 0) begin
      if (exp_port == 1) req1 = 1'b0; else req0 = 1'b0;
    end
    if (new_rad >= 0) begin
      if (exp_port == 1) rad1 = RAD_W'(new_rad); else rad0 = RAD_W'(new_rad);
    end
    steps = 0;
    while (!(done0 || done1) && steps < 40) begin
      step();
      steps++;
      chk("gnt_hold", {31'd0, gnt1}, exp_port);
    end
    chk("done_seen", {31'd0, done0 | done1}, 1);
    if (!(done0 || done1)) return;
    r   = isqrt(rad_val);
    lat = steps + 1;
    got_root  = int'(root);
    got_exact = int'(exact);
    chk("latency", lat, r + 2);
    chk("done_port", {31'd0, done1}, exp_port);
    chk("root", got_root, r);
    chk("exact", got_exact, (r * r == rad_val) ? 1 : 0);
`ifndef SQRT_SCHED_FIXED_PRIO_EN
    ptr_m = 1 - exp_port;
`endif
    if (release_mode >= 1) begin
      if (exp_port == 1) req1 = 1'b0; else req0 = 1'b0;
    end
    if (release_mode == 2) begin
      req0 = 1'b0;
      req1 = 1'b0;
    end
    step();
    chk("idle_after_done", {31'd0, busy}, 0);
    chk("done_one_cycle", {31'd0, done0 | done1}, 0);
  endtask

  initial begin
    int lat, rt, ex, w, p, dcount, nr;

    // Reset state.
    step();
    step();
    chk("rst_gnt0", {31'd0, gnt0}, 0);
    chk("rst_gnt1", {31'd0, gnt1}, 0);
    chk("rst_done0", {31'd0, done0}, 0);
    chk("rst_done1", {31'd0, done1}, 0);
    chk("rst_root", {28'd0, root}, 0);
    chk("rst_exact", {31'd0, exact}, 0);
    chk("rst_busy", {31'd0, busy}, 0);

    // Contention right out of reset: order 0,1,0,1 (round-robin) or 0,0,0,0.
    reset = 1'b1;
    req0 = 1'b1; rad0 = 8'd4;
    req1 = 1'b1; rad1 = 8'd9;
    ptr_m = 0;
    for (int k = 0; k < 4; k++) begin
      p = pick(req0, req1);
`ifdef SQRT_SCHED_FIXED_PRIO_EN
      chk("model_order", p, 0);
`else
      chk("model_order", p, k % 2);
`endif
      serve(p, 0, -1, (k == 3) ? 2 : 0, lat, rt, ex, w);
      if (k == 0) chk("first_accept_wait", w, 1);
      chk("rr_root", rt, (p == 1) ? 3 : 2);
    end

    // Directed single requests.
    req0 = 1'b1; rad0 = 8'd49;
    serve(0, 0, -1, 1, lat, rt, ex, w);
    chk("r49_lat", lat, 9);  chk("r49_root", rt, 7);  chk("r49_exact", ex, 1);
    req1 = 1'b1; rad1 = 8'd50;
    serve(1, 0, -1, 1, lat, rt, ex, w);
    chk("r50_lat", lat, 9);  chk("r50_root", rt, 7);  chk("r50_exact", ex, 0);
    req1 = 1'b1; rad1 = 8'd0;
    serve(1, 0, -1, 1, lat, rt, ex, w);
    chk("r0_lat", lat, 2);   chk("r0_root", rt, 0);   chk("r0_exact", ex, 1);
    req1 = 1'b1; rad1 = 8'd255;
    serve(1, 0, -1, 1, lat, rt, ex, w);
    chk("r255_lat", lat, 17); chk("r255_root", rt, 15); chk("r255_exact", ex, 0);

    // Request dropped and radicand changed right after accept.
    req0 = 1'b1; rad0 = 8'd16;
    serve(0, 1, 200, 1, lat, rt, ex, w);
    chk("r16_root", rt, 4);  chk("r16_exact", ex, 1);

    // Reset three cycles into an operation aborts it.
    req0 = 1'b1; rad0 = 8'd100;
    step();
    chk("abort_accept", {31'd0, gnt0}, 1);
    step();
    step();
    reset = 1'b0;
    req0  = 1'b0;
    step();
    chk("abort_gnt0", {31'd0, gnt0}, 0);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_done0", {31'd0, done0}, 0);
    chk("abort_root", {28'd0, root}, 0);
    reset = 1'b1;
    ptr_m = 0;
    dcount = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (done0 || done1) dcount++;
    end
    chk("abort_no_done", dcount, 0);
    req0 = 1'b1; rad0 = 8'd100;
    serve(0, 0, -1, 1, lat, rt, ex, w);
    chk("r100_lat", lat, 12); chk("r100_root", rt, 10); chk("r100_exact", ex, 1);

    // Randomized traffic; waiting requesters keep their request and radicand.
    for (int it = 0; it < 30; it++) begin
      if (!req0 && $urandom_range(0, 1) == 1) begin
        req0 = 1'b1; rad0 = RAD_W'($urandom_range(0, 255));
      end
      if (!req1 && $urandom_range(0, 1) == 1) begin
        req1 = 1'b1; rad1 = RAD_W'($urandom_range(0, 255));
      end
      if (!req0 && !req1) begin
        req0 = 1'b1; rad0 = RAD_W'($urandom_range(0, 255));
      end
      p  = pick(req0, req1);
      nr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : -1;
      serve(p, ($urandom_range(0, 3) == 0) ? 1 : 0, nr, 1, lat, rt, ex, w);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    step();
    step();
    chk("final_idle", {31'd0, busy}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
